adder_result_capture: RTL and testbench

- Downstream stage of the 32-bit operand adder.
- Samples the adder's operand and result lines (a, b, y) on a valid/ready handshake, computes the carry-out, and buffers {carry, sum} entries in a small synchronous FIFO.
- Entries drain to the consumer through an out_valid/out_ready handshake.
- Also counts dropped samples and, optionally, self-checks the adder's result.

---
 rtl/adder_pkg.sv | 13 +
 rtl/adder_result_capture_fifo.sv | 59 +++++
 rtl/adder_result_capture.sv | 86 ++++++++
 tb/tb_adder_result_capture.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and defaults for the adder result capture stage.
package adder_pkg;

  localparam int DATA_W        = 32;
  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_CNT_W = 16;

  typedef struct packed {
    logic              carry;
    logic [DATA_W-1:0] sum;
  } capture_entry_t;

endpackage

// File: rtl/adder_result_capture_fifo.sv
// Synchronous FIFO for capture entries: storage, pointers, occupancy, full/empty.
// Push is ignored when full and pop is ignored when empty.
module sync_fifo #(
  parameter int  WIDTH = 33,
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [LVL_W-1:0] level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      level_d = level_q + 1'b1;
    else if (!do_push && do_pop) level_d = level_q - 1'b1;
  end

  // Storage is cleared on reset so the head reads 0 while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/adder_result_capture.sv
// Captures adder a/b/y, derives carry-out, buffers {carry,sum} and counts drops.
// Optional sum self-check enabled by defining ADDER_CAPTURE_SUM_CHECK_EN.
module adder_result_capture #(
  parameter int DATA_W = adder_pkg::DATA_W,
  parameter int DEPTH  = adder_pkg::DEFAULT_DEPTH,
  parameter int CNT_W  = adder_pkg::DEFAULT_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        in_a,
  input  logic [DATA_W-1:0]        in_b,
  input  logic [DATA_W-1:0]        in_y,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        out_sum,
  output logic                     out_carry,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     sum_err
);

  logic              push, pop, full, empty;
  logic [DATA_W:0]   wr_entry, rd_entry;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  // Handshake: a transfer happens on an edge where valid and ready are both high.
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // y < a (unsigned) is exactly the carry-out of a+b modulo 2^DATA_W.
  assign wr_entry  = {(in_y < in_a), in_y};
  assign out_sum   = rd_entry[DATA_W-1:0];
  assign out_carry = rd_entry[DATA_W];

  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .rdata_o (rd_entry),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (in_valid && !in_ready && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;

`ifdef ADDER_CAPTURE_SUM_CHECK_EN
  logic sum_err_q, sum_err_d;

  always_comb begin
    sum_err_d = sum_err_q;
    if (push && (in_y != in_a + in_b)) sum_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_err_q <= 1'b0;
    else        sum_err_q <= sum_err_d;
  end

  assign sum_err = sum_err_q;
`else
  logic unused_b;
  assign unused_b = ^in_b;
  assign sum_err  = 1'b0;
`endif

endmodule

// File: tb/tb_adder_result_capture.sv
// Scoreboard bench for adder_result_capture with a queue-based reference model.
module tb_adder_result_capture;

  localparam int DATA_W   = 32;
  localparam int DEPTH    = 4;
  localparam int CNT_W    = 4;
  localparam int DROP_MAX = (1 << CNT_W) - 1;

  logic                   clk, rst_n;
  logic [DATA_W-1:0]      in_a, in_b, in_y;
  logic                   in_valid, in_ready;
  logic [DATA_W-1:0]      out_sum;
  logic                   out_carry, out_valid, out_ready;
  logic [$clog2(DEPTH):0] level;
  logic [CNT_W-1:0]       drop_cnt;
  logic                   sum_err;

  adder_result_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_y      (in_y),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .drop_cnt  (drop_cnt),
    .sum_err   (sum_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [DATA_W:0] exp_q[$];
  int              mdl_level;
  int              mdl_drop;
  logic            mdl_err;
  int              n_checks;
  int              n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W:0] make_exp(input logic [DATA_W-1:0] a, b, y);
    logic [DATA_W:0] wide;
    wide = {1'b0, a} + {1'b0, b};
    // Carry-out of the true addition when y is right; otherwise y wrapped below a.
    if (y == wide[DATA_W-1:0]) return {wide[DATA_W], y};
    return {(y < a), y};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    mdl_level = 0;
    mdl_drop  = 0;
    mdl_err   = 1'b0;
  endtask

  // One clock cycle of stimulus, then compare state outputs against the model.
  task automatic drive(input logic v, input logic [DATA_W-1:0] a, b, y, input logic r);
    bit acc, pp;
    in_valid = v; in_a = a; in_b = b; in_y = y; out_ready = r;
    acc = v && (mdl_level < DEPTH);
    pp  = r && (mdl_level > 0);
    if (acc) exp_q.push_back(make_exp(a, b, y));
    if (v && !acc && mdl_drop < DROP_MAX) mdl_drop++;
`ifdef ADDER_CAPTURE_SUM_CHECK_EN
    if (acc && (y != a + b)) mdl_err = 1'b1;
`endif
    @(posedge clk);
    #1;
    mdl_level = mdl_level + int'(acc) - int'(pp);
    check("level",     64'(level),     64'(mdl_level));
    check("in_ready",  64'(in_ready),  64'(mdl_level != DEPTH));
    check("out_valid", 64'(out_valid), 64'(mdl_level != 0));
    check("drop_cnt",  64'(drop_cnt),  64'(mdl_drop));
    check("sum_err",   64'(sum_err),   64'(mdl_err));
  endtask

  task automatic push_ok(input logic [DATA_W-1:0] a, b, input logic r);
    drive(1'b1, a, b, a + b, r);
  endtask

  task automatic idle(input logic r);
    drive(1'b0, '0, '0, '0, r);
  endtask

  // monitor: compare the head whenever the DUT hands an entry over
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL head: unexpected pop sum 0x%0h, expected no data", out_sum);
      end else begin
        check("head", 64'({out_carry, out_sum}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [DATA_W-1:0] first_y, ra;
    n_checks = 0; n_fail = 0;
    model_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_y = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_level",     64'(level),     64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_drop",      64'(drop_cnt),  64'd0);
    check("rst_sum_err",   64'(sum_err),   64'd0);
    check("rst_out_sum",   64'(out_sum),   64'd0);
    check("rst_out_carry", 64'(out_carry), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // single capture
    drive(1'b1, 32'd10, 32'd25, 32'd35, 1'b0);
    check("t1_sum",   64'(out_sum),   64'd35);
    check("t1_carry", 64'(out_carry), 64'd0);
    idle(1'b1);

    // carry detection
    drive(1'b1, 32'hFFFF_FFF0, 32'h20, 32'h10, 1'b0);
    check("t2_sum",   64'(out_sum),   64'h10);
    check("t2_carry", 64'(out_carry), 64'd1);
    idle(1'b1);

    // fill past full with the consumer stalled
    first_y = '0;
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      if (i == 0) first_y = ra + 32'd7;
      push_ok(ra, 32'd7, 1'b0);
    end
    check("t3_head", 64'(out_sum), 64'(first_y));
    idle(1'b1);
    repeat (DEPTH) idle(1'b1);

    // concurrent push/pop across two pointer wraps
    for (int i = 1; i <= 10; i++) begin
      ra = $urandom;
      drive(1'b1, ra, 32'(i) - ra, 32'(i), 1'b1);
    end
    idle(1'b1);

    // self-check: wrong sum, then correct ones
    drive(1'b1, 32'd5, 32'd7, 32'd13, 1'b1);
    for (int i = 0; i < 3; i++) push_ok($urandom, $urandom, 1'b1);
    idle(1'b1);

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1'($urandom_range(0, 1)));
      else push_ok($urandom, $urandom, 1'($urandom_range(0, 1)));
    end
    repeat (DEPTH + 1) idle(1'b1);

    // drop counter saturation
    for (int i = 0; i < DEPTH + DROP_MAX + 5; i++) push_ok($urandom, $urandom, 1'b0);
    idle(1'b1);

    // asynchronous reset between edges with entries stored
    check("t5_pre_level", 64'(level), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("t5_out_valid", 64'(out_valid), 64'd0);
    check("t5_level",     64'(level),     64'd0);
    check("t5_drop",      64'(drop_cnt),  64'd0);
    check("t5_sum_err",   64'(sum_err),   64'd0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) push_ok($urandom, $urandom, 1'($urandom_range(0, 1)));
    repeat (DEPTH + 1) idle(1'b1);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
